scan_select_sequencer: RTL
==========================

SCAN_SELECT_SEQUENCER -- requirements
Module: scan_select_sequencer

Interface
REQ-001 The block SHALL have parameter PRESCALE_W, default 8, the width of the dwell-divider input and internal counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin scanning.
REQ-005 The block SHALL have port stop, input, 1, a request to end scanning.
REQ-006 The block SHALL have port mode, input, 1, the scan mode: 0 = auto-scan, 1 = manual step.
REQ-007 The block SHALL have port div, input, PRESCALE_W, the auto-scan dwell: each address is held div+1 cycles.
REQ-008 The block SHALL have port step_req, input, 1, the manual advance request.
REQ-009 The block SHALL have port step_ack, output, 1, a one-cycle acknowledge of an accepted step.
REQ-010 The block SHALL have port sel_a, output, 1, address bit 0, driving decoder input A.
REQ-011 The block SHALL have port sel_b, output, 1, address bit 1, driving decoder input B.
REQ-012 The block SHALL have port en_n, output, 1, the active-low decoder enable, driving decoder input E.
REQ-013 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.
REQ-014 The block SHALL have port wrap, output, 1, a one-cycle pulse when the address advances from 3 to 0.

Function
REQ-015 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-016 The state machine SHALL have states IDLE and RUN, plus BLANK when BLANK_EN is defined.
REQ-017 In IDLE: en_n=1, address held, counter held at 0.
REQ-018 IDLE to RUN on start=1 and stop=0; the same edge SHALL set addr=0, counter=0, and latch mode and div; en_n=0 from the next cycle.
REQ-019 In RUN, mode and div SHALL come from the values latched at start; input changes are ignored until the next start.
REQ-020 Auto mode in RUN: counter increments each cycle; when counter==div_latched, addr advances by 1 modulo 4 and counter clears.
REQ-021 Auto mode with div=0: addr SHALL advance every cycle (BLANK_EN undefined).
REQ-022 Manual mode in RUN: a step occurs on a rising edge of step_req (registered previous value 0, current value 1); addr advances by 1 modulo 4.
REQ-023 Manual mode: step_ack SHALL pulse high for exactly one cycle, the cycle after the step is accepted.
REQ-024 Manual mode: a held-high step_req SHALL yield a single step; the counter is unused.
REQ-025 wrap SHALL pulse for one cycle, coincident with the address changing from 3 to 0, in either mode.
REQ-026 stop=1 in RUN or BLANK: next state IDLE, en_n=1, addr held, no step_ack or wrap generated on that edge.
REQ-027 start while busy SHALL be ignored; start and stop asserted together SHALL resolve as stop wins (remain or go IDLE).
REQ-028 step_req in IDLE or in auto mode SHALL be ignored, with step_ack held at 0.
REQ-029 sel_b:sel_a SHALL always equal the current 2-bit address.

Reset
REQ-030 On rst=1 at a clock edge: state IDLE, addr=0, counter=0, en_n=1, step_ack=0, wrap=0, busy=0, step_req history=0.
REQ-031 Reset SHALL override all other inputs, including mid-scan and mid-handshake; rst asserted during a step SHALL suppress step_ack.

Configuration
REQ-032 Macro SCAN_SELECT_BLANK_EN, when defined, SHALL make every address advance go via BLANK: the addr update and en_n=1 occur in BLANK for one cycle, then RUN resumes with en_n=0 and counter=0.
REQ-033 With SCAN_SELECT_BLANK_EN defined, the auto-mode period per address SHALL be div+2 cycles, and wrap SHALL pulse on entry to BLANK.
REQ-034 With SCAN_SELECT_BLANK_EN undefined, there SHALL be no BLANK state and en_n SHALL stay 0 continuously throughout RUN.

Verification
REQ-035 Auto, div=2, no blank: pulse start -> addr sequence 0,0,0,1,1,1,2,2,2,3,3,3,0, with wrap high on the cycle addr returns to 0; en_n=0 throughout.
REQ-036 Auto, div=0, with BLANK_EN: start -> en_n pattern 0,1,0,1,...; addr changes only in en_n=1 cycles; period 2 cycles per address.
REQ-037 Manual: start with mode=1; pulse step_req 3 times, with one pulse held 5 cycles -> addr 0 to 1 to 2 to 3; exactly three step_ack pulses, each one cycle.
REQ-038 Assert start and stop together in IDLE -> busy stays 0; later assert stop in RUN at addr=2 -> next cycle busy=0, en_n=1, addr=2.
REQ-039 Assert rst mid-scan at addr=3 while stepping -> next cycle addr=0, en_n=1, busy=0, step_ack=0, wrap=0.

Source files
------------

// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer
// Drives the A/B select lines and active-low enable of a 2-to-4 decoder.
// Auto mode dwells div+1 cycles on each address; manual mode advances one
// address per rising edge of step_req and acknowledges it for one cycle.
// Optional feature macro: SCAN_SELECT_BLANK_EN. When defined, every address
// advance passes through a one-cycle BLANK state with the decoder disabled.
// Reset is synchronous and active-high.
module scan_select_sequencer #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  step_req,
    output logic                  step_ack,
    output logic                  sel_a,
    output logic                  sel_b,
    output logic                  en_n,
    output logic                  busy,
    output logic                  wrap
);

    localparam logic [PRESCALE_W-1:0] CNT_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] CNT_ONE  = PRESCALE_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
`ifdef SCAN_SELECT_BLANK_EN
        ST_BLANK = 2'b10,
`endif
        ST_RUN   = 2'b01
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [1:0]              addr_r;
    logic [1:0]              addr_s;
    logic [PRESCALE_W-1:0]   cnt_r;
    logic [PRESCALE_W-1:0]   cnt_s;
    logic [PRESCALE_W-1:0]   div_r;
    logic [PRESCALE_W-1:0]   div_s;
    logic                    mode_r;
    logic                    mode_s;
    logic                    step_prev_r;
    logic                    step_rise_s;
    logic                    adv_s;
    logic                    step_ack_r;
    logic                    step_ack_s;
    logic                    wrap_r;
    logic                    wrap_s;
    logic                    en_n_r;
    logic                    en_n_s;
    logic                    busy_r;
    logic                    busy_s;

    // Next-state, datapath and next-output decode for the scan sequencer.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        cnt_s       = cnt_r;
        mode_s      = mode_r;
        div_s       = div_r;
        step_ack_s  = 1'b0;
        wrap_s      = 1'b0;
        adv_s       = 1'b0;
        step_rise_s = step_req & ~step_prev_r;

        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    state_s = ST_RUN;
                    addr_s  = 2'd0;
                    mode_s  = mode;
                    div_s   = div;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (!mode_r) begin
                    // auto mode: dwell until the counter reaches the latched divider
                    if (cnt_r == div_r) begin
                        adv_s = 1'b1;
                        cnt_s = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    // manual mode: counter idle, advance on a fresh step_req edge only
                    cnt_s = CNT_ZERO;
                    if (step_rise_s) begin
                        adv_s      = 1'b1;
                        step_ack_s = 1'b1;
                    end else begin
                        step_ack_s = 1'b0;
                    end
                end
            end
`ifdef SCAN_SELECT_BLANK_EN
            ST_BLANK: begin
                cnt_s = CNT_ZERO;
                if (stop) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
                addr_s  = 2'd0;
                cnt_s   = CNT_ZERO;
            end
        endcase

        if (adv_s) begin
            addr_s = addr_r + 2'd1;
            wrap_s = (addr_r == 2'd3);
`ifdef SCAN_SELECT_BLANK_EN
            // decoder is disabled for the cycle in which the address moves
            state_s = ST_BLANK;
`endif
        end else begin
            wrap_s = 1'b0;
        end

        en_n_s = (state_s != ST_RUN);
        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= 2'd0;
            cnt_r       <= CNT_ZERO;
            div_r       <= CNT_ZERO;
            mode_r      <= 1'b0;
            step_prev_r <= 1'b0;
            step_ack_r  <= 1'b0;
            wrap_r      <= 1'b0;
            en_n_r      <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            cnt_r       <= cnt_s;
            div_r       <= div_s;
            mode_r      <= mode_s;
            step_prev_r <= step_req;
            step_ack_r  <= step_ack_s;
            wrap_r      <= wrap_s;
            en_n_r      <= en_n_s;
            busy_r      <= busy_s;
        end
    end

    assign sel_a    = addr_r[0];
    assign sel_b    = addr_r[1];
    assign en_n     = en_n_r;
    assign busy     = busy_r;
    assign step_ack = step_ack_r;
    assign wrap     = wrap_r;

endmodule
